// File: rtl/bus_pkg.sv
// Shared types and width helpers for the bus_stream_master slice.
//   wr_state_t : write-channel FSM states
//   rd_state_t : read-channel FSM states
//   cnt_width  : word-counter width, $clog2(max(words,2))
//   ptr_width  : FIFO pointer width for a power-of-two depth
package bus_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_REQ  = 1'b1
  } rd_state_t;

  function automatic int cnt_width(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Single-clock show-ahead FIFO absorbing write-channel back-pressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   head       : word at the FIFO head, valid whenever !empty
//   full/empty : registered status flags
//   count      : number of stored words
module bus_sync_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  // Flags are registered, so a pop in the same cycle never makes room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; contents are meaningless once the pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bus_stream_master.sv
// Dual-channel Avalon-MM master for the frame buffer.
// Write channel: iData/iValid stream -> FIFO -> consecutive word writes into a
// wrapping region of WR_WORDS words at WR_BASE. iReady = !full; wr_overflow is
// a sticky flag for words offered while full.
// Read channel: read_init (in idle) fetches RD_WORDS consecutive words from
// RD_BASE and emits them on oData/oValid, with rd_done on the last word.
//   ctrl_clk, reset_n            : clock, asynchronous active-low reset
//   avm_write_* / avm_writedata  : write master port
//   avm_read_* / avm_readdata    : read master port
module bus_stream_master
  import bus_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_BASE    = 0,
  parameter int WR_WORDS   = 76800,
  parameter int RD_BASE    = 0,
  parameter int RD_WORDS   = 76800
) (
  input  logic              ctrl_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  output logic              iReady,
  output logic              wr_overflow,
  output logic [ADDR_W-1:0] avm_write_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_write_waitrequest,
  input  logic              read_init,
  output logic [ADDR_W-1:0] avm_read_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_read_waitrequest,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              rd_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int WCW   = cnt_width(WR_WORDS);
  localparam int RCW   = cnt_width(RD_WORDS);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
  localparam logic [WCW-1:0]    WR_LAST   = WCW'(WR_WORDS - 1);
  localparam logic [RCW-1:0]    RD_LAST   = RCW'(RD_WORDS - 1);

  wr_state_t      wr_state, wr_state_nxt;
  rd_state_t      rd_state, rd_state_nxt;
  logic [WCW-1:0] wr_cnt;
  logic [RCW-1:0] rd_cnt;
  logic           wr_accept;
  logic           rd_accept;
  logic           rd_last;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;

  // ---------------- write channel ----------------
  bus_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ctrl_clk),
    .rst_n (reset_n),
    .push  (iValid),
    .din   (iData),
    .pop   (wr_accept),
    .head  (avm_writedata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign iReady    = !fifo_full;
  assign wr_accept = avm_write && !avm_write_waitrequest;

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) wr_state <= W_IDLE;
    else          wr_state <= wr_state_nxt;
  end

  // Staying in W_REQ needs a second word behind the one being accepted;
  // the head after the pop is only visible through the registered pointers.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (!fifo_empty) wr_state_nxt = W_REQ;
      W_REQ:   if (wr_accept && (fifo_count < FCW'(2))) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    avm_write = (wr_state == W_REQ);
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_write_address <= WR_BASE_A;
      wr_cnt            <= '0;
      wr_overflow       <= 1'b0;
    end else begin
      if (iValid && fifo_full) wr_overflow <= 1'b1;
      if (wr_accept) begin
        if (wr_cnt == WR_LAST) begin
          avm_write_address <= WR_BASE_A;
          wr_cnt            <= '0;
        end else begin
          avm_write_address <= avm_write_address + STEP;
          wr_cnt            <= wr_cnt + WCW'(1);
        end
      end
    end
  end

  // ---------------- read channel ----------------
  assign rd_accept = avm_read && !avm_read_waitrequest;
  assign rd_last   = (rd_cnt == RD_LAST);

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) rd_state <= R_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (read_init) rd_state_nxt = R_REQ;
      R_REQ:   if (rd_accept && rd_last) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    avm_read = (rd_state == R_REQ);
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read_address <= RD_BASE_A;
      rd_cnt           <= '0;
      oData            <= '0;
      oValid           <= 1'b0;
      rd_done          <= 1'b0;
    end else begin
      oValid  <= rd_accept;
      rd_done <= rd_accept && rd_last;
      if (rd_accept) begin
        oData <= avm_readdata;
        if (rd_last) begin
          avm_read_address <= RD_BASE_A;
          rd_cnt           <= '0;
        end else begin
          avm_read_address <= avm_read_address + STEP;
          rd_cnt           <= rd_cnt + RCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_stream_master.sv
module tb_bus_stream_master;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int FD  = 4;
  localparam int WRW = 6;
  localparam int RDW = 4;
  localparam logic [31:0] WB = 32'h100;
  localparam logic [31:0] RB = 32'h200;

  logic          ctrl_clk;
  logic          reset_n;
  logic [DW-1:0] iData;
  logic          iValid;
  logic          iReady;
  logic          wr_overflow;
  logic [AW-1:0] avm_write_address;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_write_waitrequest;
  logic          read_init;
  logic [AW-1:0] avm_read_address;
  logic          avm_read;
  logic [DW-1:0] avm_readdata;
  logic          avm_read_waitrequest;
  logic [DW-1:0] oData;
  logic          oValid;
  logic          rd_done;

  bus_stream_master #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD),
    .WR_BASE(32'h100), .WR_WORDS(WRW), .RD_BASE(32'h200), .RD_WORDS(RDW)
  ) dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n),
    .iData(iData), .iValid(iValid), .iReady(iReady), .wr_overflow(wr_overflow),
    .avm_write_address(avm_write_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_write_waitrequest(avm_write_waitrequest),
    .read_init(read_init), .avm_read_address(avm_read_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_read_waitrequest(avm_read_waitrequest),
    .oData(oData), .oValid(oValid), .rd_done(rd_done)
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  // Reference model: FIFO contents as a queue, write word index, read frame progress.
  logic [31:0] wq[$];
  int          wk;
  logic        ovf_m;
  logic        rbusy;
  int          ridx;
  logic        ov_m;
  logic        done_m;
  logic [31:0] od_m;
  logic [31:0] salt;
  int          frames;
  int          strobes;
  int          n_vec;
  int          n_err;

  task automatic model_reset();
    wq.delete();
    wk = 0; ovf_m = 1'b0; rbusy = 1'b0; ridx = 0;
    ov_m = 1'b0; done_m = 1'b0; od_m = '0;
  endtask

  task automatic idle_inputs();
    iValid = 1'b0; iData = '0; avm_write_waitrequest = 1'b0;
    read_init = 1'b0; avm_read_waitrequest = 1'b0; avm_readdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge ctrl_clk);
    reset_n = 1'b1;
  endtask

  // One clock cycle of both channels: drive, compare against the model, advance the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic wwt,
                       input logic init, input logic rwt);
    logic [31:0] wa_exp;
    logic [31:0] ra_exp;
    logic        full_m;
    logic        wacc;
    iValid = v; iData = d; avm_write_waitrequest = wwt;
    read_init = init; avm_read_waitrequest = rwt;
    avm_readdata = avm_read_address ^ salt;
    #1;
    full_m = (wq.size() >= FD);
    wa_exp = WB + 32'(4 * (wk % WRW));
    ra_exp = RB + 32'(4 * ridx);
    n_vec++; if (iReady !== !full_m) begin n_err++; $display("FAIL iReady got %b exp %b", iReady, !full_m); end
    n_vec++; if (wr_overflow !== ovf_m) begin n_err++; $display("FAIL wr_overflow got %b exp %b", wr_overflow, ovf_m); end
    n_vec++; if (avm_write_address !== wa_exp) begin n_err++; $display("FAIL wr_addr got %h exp %h", avm_write_address, wa_exp); end
    if (avm_write === 1'b1) begin
      n_vec++;
      if (wq.size() == 0) begin n_err++; $display("FAIL wr_empty got avm_write=1 exp 0 with empty FIFO"); end
      else if (avm_writedata !== wq[0]) begin n_err++; $display("FAIL wr_data got %h exp %h", avm_writedata, wq[0]); end
    end
    n_vec++; if (avm_read !== rbusy) begin n_err++; $display("FAIL avm_read got %b exp %b", avm_read, rbusy); end
    n_vec++; if (avm_read_address !== ra_exp) begin n_err++; $display("FAIL rd_addr got %h exp %h", avm_read_address, ra_exp); end
    n_vec++; if (oValid !== ov_m) begin n_err++; $display("FAIL oValid got %b exp %b", oValid, ov_m); end
    n_vec++; if (oData !== od_m) begin n_err++; $display("FAIL oData got %h exp %h", oData, od_m); end
    n_vec++; if (rd_done !== done_m) begin n_err++; $display("FAIL rd_done got %b exp %b", rd_done, done_m); end
    wacc = (avm_write === 1'b1) && !wwt && (wq.size() > 0);
    if (wacc) begin void'(wq.pop_front()); wk++; end
    if (v && !full_m) wq.push_back(d);
    if (v && full_m) ovf_m = 1'b1;
    ov_m = 1'b0; done_m = 1'b0;
    if (rbusy && !rwt) begin
      ov_m = 1'b1; od_m = ra_exp ^ salt; strobes++;
      if (ridx == RDW - 1) begin done_m = 1'b1; frames++; ridx = 0; rbusy = 1'b0; end
      else ridx++;
    end else if (!rbusy && init) begin
      rbusy = 1'b1;
    end
    @(negedge ctrl_clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    salt = '0;
    repeat (2) @(negedge ctrl_clk);
    n_vec++; if (avm_write !== 1'b0) begin n_err++; $display("FAIL rst_avm_write got %b exp 0", avm_write); end
    n_vec++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL rst_avm_read got %b exp 0", avm_read); end
    n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL rst_oValid got %b exp 0", oValid); end
    n_vec++; if (rd_done !== 1'b0) begin n_err++; $display("FAIL rst_rd_done got %b exp 0", rd_done); end
    n_vec++; if (wr_overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b exp 0", wr_overflow); end
    n_vec++; if (iReady !== 1'b1) begin n_err++; $display("FAIL rst_iReady got %b exp 1", iReady); end
    n_vec++; if (avm_write_address !== WB) begin n_err++; $display("FAIL rst_wr_addr got %h exp %h", avm_write_address, WB); end
    n_vec++; if (avm_read_address !== RB) begin n_err++; $display("FAIL rst_rd_addr got %h exp %h", avm_read_address, RB); end
    n_vec++; if (oData !== '0) begin n_err++; $display("FAIL rst_oData got %h exp 0", oData); end
    reset_n = 1'b1;
  endtask

  task automatic test_write_stream();
    int k;
    int g;
    apply_reset();
    k = 0; g = 0;
    while (k < 7 && g < 50) begin
      if (wq.size() < FD) begin cycle(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b0); k++; end
      else cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      g++;
    end
    g = 0;
    while (wq.size() != 0 && g < 20) begin cycle(1'b0, '0, 1'b0, 1'b0, 1'b0); g++; end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wk !== 7) begin n_err++; $display("FAIL stream_count got %0d exp 7", wk); end
    n_vec++; if (avm_write_address !== 32'h104) begin n_err++; $display("FAIL stream_wrap got %h exp 104", avm_write_address); end
    n_vec++; if (avm_write !== 1'b0) begin n_err++; $display("FAIL stream_idle got %b exp 0", avm_write); end
  endtask

  task automatic test_write_stall();
    int g;
    apply_reset();
    cycle(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0);
    g = 0;
    while (avm_write !== 1'b1 && g < 5) begin cycle(1'b0, '0, 1'b1, 1'b0, 1'b0); g++; end
    n_vec++; if (avm_write !== 1'b1) begin n_err++; $display("FAIL stall_req got %b exp 1", avm_write); end
    for (int i = 0; i < 5; i++) cycle(i < 3, 32'hA1 + 32'(i), 1'b1, 1'b0, 1'b0);
    n_vec++; if (avm_writedata !== 32'hA0) begin n_err++; $display("FAIL stall_data got %h exp a0", avm_writedata); end
    n_vec++; if (iReady !== 1'b0) begin n_err++; $display("FAIL stall_fill got %b exp 0", iReady); end
    n_vec++; if (wk !== 0) begin n_err++; $display("FAIL stall_nopop got %0d exp 0", wk); end
    g = 0;
    while (wq.size() != 0 && g < 20) begin cycle(1'b0, '0, 1'b0, 1'b0, 1'b0); g++; end
    n_vec++; if (wk !== 4) begin n_err++; $display("FAIL stall_drain got %0d exp 4", wk); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0);
    n_vec++; if (iReady !== 1'b0) begin n_err++; $display("FAIL ovf_ready got %b exp 0", iReady); end
    n_vec++; if (wr_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", wr_overflow); end
    repeat (10) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", wr_overflow); end
    n_vec++; if (wk !== 4) begin n_err++; $display("FAIL ovf_kept got %0d exp 4", wk); end
  endtask

  task automatic test_read_frame();
    int f0;
    int s0;
    int g;
    apply_reset();
    salt = '0; f0 = frames; s0 = strobes;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    g = 0;
    while (frames == f0 && g < 20) begin cycle(1'b0, '0, 1'b0, 1'b0, 1'b0); g++; end
    n_vec++; if (g !== RDW) begin n_err++; $display("FAIL frame_time got %0d exp %0d", g + 1, RDW + 1); end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (strobes - s0 !== 4) begin n_err++; $display("FAIL frame_words got %0d exp 4", strobes - s0); end
    n_vec++; if (oData !== 32'h20C) begin n_err++; $display("FAIL frame_last got %h exp 20c", oData); end
  endtask

  task automatic test_read_stall();
    int f0;
    int s0;
    int g;
    salt = $urandom; f0 = frames; s0 = strobes;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    g = 0;
    while (frames == f0 && g < 40) begin
      cycle(1'b0, '0, 1'b0, (g == 3 || g == 6), (g % 2 == 0));
      g++;
    end
    repeat (6) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (frames - f0 !== 1) begin n_err++; $display("FAIL stall_frames got %0d exp 1", frames - f0); end
    n_vec++; if (strobes - s0 !== 4) begin n_err++; $display("FAIL stall_words got %0d exp 4", strobes - s0); end
    n_vec++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL stall_noframe got %b exp 0", avm_read); end
  endtask

  task automatic test_random();
    int g;
    apply_reset();
    salt = $urandom;
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom % 2), $urandom, ($urandom % 4 == 0), ($urandom % 8 == 0), ($urandom % 3 == 0));
    g = 0;
    while ((wq.size() != 0 || rbusy) && g < 40) begin cycle(1'b0, '0, 1'b0, 1'b0, 1'b0); g++; end
    n_vec++; if (wq.size() !== 0) begin n_err++; $display("FAIL rand_drain got %0d exp 0", wq.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    int g;
    apply_reset();
    salt = '0;
    cycle(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hC1, 1'b1, 1'b1, 1'b0);
    s0 = strobes; g = 0;
    while (strobes - s0 < 2 && g < 20) begin cycle(1'b0, '0, 1'b1, 1'b0, (g % 2 == 1)); g++; end
    avm_write_waitrequest = 1'b1;
    read_init = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (avm_write !== 1'b0) begin n_err++; $display("FAIL mid_avm_write got %b exp 0", avm_write); end
    n_vec++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL mid_avm_read got %b exp 0", avm_read); end
    n_vec++; if (oValid !== 1'b0) begin n_err++; $display("FAIL mid_oValid got %b exp 0", oValid); end
    n_vec++; if (rd_done !== 1'b0) begin n_err++; $display("FAIL mid_rd_done got %b exp 0", rd_done); end
    n_vec++; if (iReady !== 1'b1) begin n_err++; $display("FAIL mid_iReady got %b exp 1", iReady); end
    n_vec++; if (avm_write_address !== WB) begin n_err++; $display("FAIL mid_wr_addr got %h exp %h", avm_write_address, WB); end
    n_vec++; if (avm_read_address !== RB) begin n_err++; $display("FAIL mid_rd_addr got %h exp %h", avm_read_address, RB); end
    n_vec++; if (oData !== '0) begin n_err++; $display("FAIL mid_oData got %h exp 0", oData); end
    idle_inputs();
    model_reset();
    @(negedge ctrl_clk);
    reset_n = 1'b1;
    s0 = strobes;
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (RDW + 2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (strobes - s0 !== 4) begin n_err++; $display("FAIL mid_restart got %0d exp 4", strobes - s0); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; frames = 0; strobes = 0;
    test_reset();
    test_write_stream();
    test_write_stall();
    test_overflow();
    test_read_frame();
    test_read_stall();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
